cpu_mc: RTL and testbench

Multicycle, width-parametrised successor to the single-cycle Hack CPU core. It executes the Hack A/C instruction set over a fetch/load/execute/store state machine. Instruction and data memories sit behind valid/ready handshakes, so wait-stated ROM/RAM and shared buses can be attached. Adds a retired-instruction counter and self-loop halt detection. It sits between the instruction ROM port and the data-bus arbiter in the computer top level.

---
 rtl/cpu_mc_pkg.sv | 32 +++
 rtl/cpu_mc_alu.sv | 31 +++
 rtl/cpu_mc.sv | 176 +++++++++++++++++
 tb/tb_cpu_mc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle Hack core: FSM states, C-instruction
// field positions and the jump-condition helper.
package cpu_mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        EXEC,
        STORE,
        HALT
    } state_e;

    localparam int BIT_A   = 12;
    localparam int BIT_ZX  = 11;
    localparam int BIT_NX  = 10;
    localparam int BIT_ZY  = 9;
    localparam int BIT_NY  = 8;
    localparam int BIT_F   = 7;
    localparam int BIT_NO  = 6;
    localparam int BIT_DA  = 5;
    localparam int BIT_DD  = 4;
    localparam int BIT_DM  = 3;
    localparam int BIT_JLT = 2;
    localparam int BIT_JEQ = 1;
    localparam int BIT_JGT = 0;

    // jmp is {jlt, jeq, jgt} exactly as it sits in the instruction.
    function automatic logic jump_cond(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational Hack ALU, parametrised in width, with zero/negative flags.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             zx_i,
    input  logic             nx_i,
    input  logic             zy_i,
    input  logic             ny_i,
    input  logic             f_i,
    input  logic             no_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o
);

    logic [WIDTH-1:0] xz, xn, yz, yn, fo;

    always_comb begin
        xz    = zx_i ? '0 : x_i;
        xn    = nx_i ? ~xz : xz;
        yz    = zy_i ? '0 : y_i;
        yn    = ny_i ? ~yz : yz;
        fo    = f_i ? (xn + yn) : (xn & yn);
        out_o = no_i ? ~fo : fo;
        zr_o  = (out_o == '0);
        ng_o  = out_o[WIDTH-1];
    end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle Hack CPU: FETCH/LOAD/EXEC/STORE/HALT over handshaked instruction
// and data ports, with a retired-instruction counter and self-loop halt.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 15
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [WIDTH-1:0]    instruction,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic                dmem_ready,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic [WIDTH-1:0]    instret,
    output logic                halted
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    dreg_q, dreg_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic [WIDTH-1:0]    mdr_q, mdr_d;
    logic [WIDTH-1:0]    instret_q, instret_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                halt_pend_q, halt_pend_d;

    logic                is_c;
    logic [WIDTH-1:0]    alu_out;
    logic                alu_zr, alu_ng;
    logic                take;
    logic                self_loop;
    logic [PC_WIDTH-1:0] pc_next;

    assign is_c = ir_q[WIDTH-1];

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x_i   (dreg_q),
        .y_i   (ir_q[BIT_A] ? mdr_q : a_q),
        .zx_i  (ir_q[BIT_ZX]),
        .nx_i  (ir_q[BIT_NX]),
        .zy_i  (ir_q[BIT_ZY]),
        .ny_i  (ir_q[BIT_NY]),
        .f_i   (ir_q[BIT_F]),
        .no_i  (ir_q[BIT_NO]),
        .out_o (alu_out),
        .zr_o  (alu_zr),
        .ng_o  (alu_ng)
    );

    // A-instruction values land in the jump field, so jumps are gated by is_c.
    assign take      = is_c & jump_cond(ir_q[BIT_JLT:BIT_JGT], alu_zr, alu_ng);
    assign self_loop = take && (a_q[PC_WIDTH-1:0] == pc_q);
    assign pc_next   = take ? a_q[PC_WIDTH-1:0] : pc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        dreg_d      = dreg_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        instret_d   = instret_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        halt_pend_d = halt_pend_q;

        unique case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    ir_d = instruction;
                    if (instruction[WIDTH-1] && instruction[BIT_A]) begin
                        state_d = LOAD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = a_q;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            LOAD: begin
                if (dmem_ready) begin
                    mdr_d   = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d = pc_next;
                if (!is_c) begin
                    a_d = {1'b0, ir_q[WIDTH-2:0]};
                end else begin
                    if (ir_q[BIT_DA]) a_d = alu_out;
                    if (ir_q[BIT_DD]) dreg_d = alu_out;
                end
                // Store address is the A value from before this instruction.
                if (is_c && ir_q[BIT_DM]) begin
                    req_d       = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = a_q;
                    wdata_d     = alu_out;
                    halt_pend_d = self_loop;
                    state_d     = STORE;
                end else begin
                    instret_d = instret_q + 1'b1;
                    state_d   = self_loop ? HALT : FETCH;
                end
            end
            STORE: begin
                if (dmem_ready) begin
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    instret_d = instret_q + 1'b1;
                    state_d   = halt_pend_q ? HALT : FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            dreg_q      <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            instret_q   <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            dreg_q      <= dreg_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            instret_q   <= instret_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign instret    = instret_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: small ROM, wait-stated data responder and a
// scoreboard of expected stores popped as the core completes each write.
module tb_cpu_mc;

    localparam int WIDTH    = 16;
    localparam int PC_WIDTH = 15;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } storeT;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid = 1'b1;
    logic [WIDTH-1:0]    instruction;
    logic                dmem_req;
    logic                dmem_we;
    logic [WIDTH-1:0]    dmem_addr;
    logic [WIDTH-1:0]    dmem_wdata;
    logic                dmem_ready = 1'b0;
    logic [WIDTH-1:0]    dmem_rdata;
    logic [WIDTH-1:0]    instret;
    logic                halted;

    logic [WIDTH-1:0]    rom [0:127];
    logic [WIDTH-1:0]    rdataVal = '0;
    storeT               expQ[$];
    storeT               popped;

    int checks = 0;
    int errors = 0;
    int waitStates = 0;
    int waitCnt = 0;
    int reqCount = 0;
    int lastLoadCycles = 0;
    logic [WIDTH-1:0]    lastLoadAddr = '0;
    bit                  lastLoadStable = 1'b0;
    logic [2*WIDTH:0]    curBus = '0;
    bit                  curStable = 1'b0;

    always #5 clk = ~clk;

    assign instruction = rom[imem_addr[6:0]];
    assign dmem_rdata  = rdataVal;

    cpu_mc #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .instruction (instruction),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .instret     (instret),
        .halted      (halted)
    );

    // Data-side responder and store monitor: inserts waitStates idle cycles per
    // request, checks the bus stays stable, and pops the scoreboard on writes.
    always @(negedge clk) begin
        if (reset || !dmem_req) begin
            dmem_ready = 1'b0;
            waitCnt    = 0;
        end else begin
            reqCount++;
            if (waitCnt == 0) begin
                curBus    = {dmem_we, dmem_addr, dmem_wdata};
                curStable = 1'b1;
            end else if ({dmem_we, dmem_addr, dmem_wdata} !== curBus) begin
                curStable = 1'b0;
            end
            if (waitCnt >= waitStates) begin
                dmem_ready = 1'b1;
                if (dmem_we) begin
                    checks++;
                    assert (expQ.size() != 0) else begin
                        errors++;
                        $error("[TB] FAIL store_unexpected: observed addr 0x%0h data 0x%0h, expected no store",
                               dmem_addr, dmem_wdata);
                    end
                    if (expQ.size() != 0) begin
                        popped = expQ.pop_front();
                        checks++;
                        assert (dmem_addr === popped.addr && dmem_wdata === popped.data && curStable) else begin
                            errors++;
                            $error("[TB] FAIL store: observed addr 0x%0h data 0x%0h stable %0d, expected addr 0x%0h data 0x%0h stable 1",
                                   dmem_addr, dmem_wdata, curStable, popped.addr, popped.data);
                        end
                    end
                end else begin
                    lastLoadCycles = waitCnt + 1;
                    lastLoadAddr   = curBus[2*WIDTH-1:WIDTH];
                    lastLoadStable = curStable;
                end
                waitCnt = 0;
            end else begin
                dmem_ready = 1'b0;
                waitCnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic holdReset();
        @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        waitStates = 0;
        for (int i = 0; i < 128; i++) rom[i] = '0;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expectStore(input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] data);
        storeT s;
        s.addr = addr;
        s.data = data;
        expQ.push_back(s);
    endtask

    task automatic waitStoresDone(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_stores_done"}, 32'(expQ.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int reqBefore;

        $display("[TB] start");
        for (int i = 0; i < 128; i++) rom[i] = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_dmem_we", 32'(dmem_we), 32'd0);
        checkOutput("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        checkOutput("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        checkOutput("rst_instret", 32'(instret), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);

        // Store after A-instruction: @0x0AA1; M=A
        holdReset();
        rom[0] = 16'h0AA1;
        rom[1] = 16'hEC08;
        expectStore(16'h0AA1, 16'h0AA1);
        releaseReset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_instret_5cyc", 32'(instret), 32'd2);
        checkOutput("t1_stores_done", 32'(expQ.size()), 32'd0);

        // Read-modify-write with 3 wait states: @0x0AA1; AM=M+1; M=D
        holdReset();
        waitStates = 3;
        rdataVal   = 16'h0AA1;
        rom[0] = 16'h0AA1;
        rom[1] = 16'hFDE8;
        rom[2] = 16'hE308;
        expectStore(16'h0AA1, 16'h0AA2);
        expectStore(16'h0AA2, 16'h0000);
        releaseReset();
        waitStoresDone("t2", 100);
        checkOutput("t2_load_req_cycles", 32'(lastLoadCycles), 32'd4);
        checkOutput("t2_load_addr", 32'(lastLoadAddr), 32'h0AA1);
        checkOutput("t2_load_stable", 32'(lastLoadStable), 32'd1);

        // A/D datapath: @5; D=A; A=D+1; M=D
        holdReset();
        rom[0] = 16'h0005;
        rom[1] = 16'hEC10;
        rom[2] = 16'hE7E0;
        rom[3] = 16'hE308;
        expectStore(16'h0006, 16'h0005);
        releaseReset();
        waitStoresDone("t3", 60);

        // Jumps: @100; D=0; D;JGT (not taken); D=-1; @100; D;JLT (taken)
        holdReset();
        rom[0] = 16'h0064;
        rom[1] = 16'hEA90;
        rom[2] = 16'hE301;
        rom[3] = 16'hEE90;
        rom[4] = 16'h0064;
        rom[5] = 16'hE304;
        releaseReset();
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_jgt_not_taken_pc", 32'(imem_addr), 32'd3);
        checkOutput("t4_instret_3", 32'(instret), 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_jlt_taken_pc", 32'(imem_addr), 32'd100);
        checkOutput("t4_instret_6", 32'(instret), 32'd6);

        // Halt: @7 at pc 6, 0;JMP at pc 7
        holdReset();
        rom[6] = 16'h0007;
        rom[7] = 16'hEA87;
        releaseReset();
        n = 0;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_halted", 32'(halted), 32'd1);
        checkOutput("t5_instret_at_halt", 32'(instret), 32'd8);
        checkOutput("t5_pc_at_halt", 32'(imem_addr), 32'd7);
        reqBefore = reqCount;
        repeat (10) @(negedge clk);
        checkOutput("t5_no_req_after_halt", 32'(reqCount), 32'(reqBefore));
        checkOutput("t5_instret_frozen", 32'(instret), 32'd8);
        checkOutput("t5_still_halted", 32'(halted), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_async_rst_halted", 32'(halted), 32'd0);
        checkOutput("t5_async_rst_pc", 32'(imem_addr), 32'd0);
        checkOutput("t5_async_rst_instret", 32'(instret), 32'd0);

        // Reset mid-LOAD with ready held low: @3; D=M
        holdReset();
        waitStates = 1000;
        rom[0] = 16'h0003;
        rom[1] = 16'hFC10;
        releaseReset();
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_load_req", 32'(dmem_req), 32'd1);
        checkOutput("t6_load_we", 32'(dmem_we), 32'd0);
        checkOutput("t6_load_addr", 32'(dmem_addr), 32'd3);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_rst_req", 32'(dmem_req), 32'd0);
        checkOutput("t6_async_rst_addr", 32'(dmem_addr), 32'd0);
        checkOutput("t6_async_rst_pc", 32'(imem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t6_first_fetch_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        checkOutput("t6_fetch0_pc_held", 32'(imem_addr), 32'd0);
        @(negedge clk);
        checkOutput("t6_pc_after_a_instr", 32'(imem_addr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
